// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: period select codes, fixed control and
// guard-band symbols, the signed disparity type and small helpers.
package tmds_pkg;

  typedef enum logic [1:0] {
    PER_CTRL  = 2'b00,
    PER_GUARD = 2'b01,
    PER_VIDEO = 2'b10
  } period_e;

  typedef logic signed [5:0] disp_t;

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  localparam logic [9:0] GUARD_02 = 10'b1011001100;
  localparam logic [9:0] GUARD_1  = 10'b0100110011;

  localparam disp_t DISP_ZERO = 6'sd0;
  localparam disp_t DISP_TWO  = 6'sd2;

  // 11 on the select is reserved and handled as blanking.
  function automatic period_e to_period(input logic [1:0] sel);
    period_e p;
    unique case (sel)
      2'b01:   p = PER_GUARD;
      2'b10:   p = PER_VIDEO;
      default: p = PER_CTRL;
    endcase
    return p;
  endfunction

  function automatic logic [9:0] ctrl_code(input logic [1:0] c);
    logic [9:0] s;
    unique case (c)
      2'b00:   s = CTRL_00;
      2'b01:   s = CTRL_01;
      2'b10:   s = CTRL_10;
      default: s = CTRL_11;
    endcase
    return s;
  endfunction

  // Signed (ones - zeros) from two 4-bit unsigned counts.
  function automatic disp_t ones_minus_zeros(
    input logic [3:0] n1,
    input logic [3:0] n0
  );
    disp_t a;
    disp_t b;
    a = {2'b00, n1};
    b = {2'b00, n0};
    return a - b;
  endfunction

endpackage

// File: rtl/tmds_qm_stage.sv
// Transition-minimising first step of TMDS video coding plus popcount.
// Ports: data_i pixel byte; qm_o 9-bit q_m; n1q_o/n0q_o ones/zeros of q_m[7:0].
module tmds_qm_stage
  import tmds_pkg::*;
(
  input  logic [7:0] data_i,
  output logic [8:0] qm_o,
  output logic [3:0] n1q_o,
  output logic [3:0] n0q_o
);

  logic [3:0] n1d;
  logic       use_xnor;

  always_comb begin
    n1d = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n1d = n1d + {3'b000, data_i[i]};
    end
  end

  // XNOR when the byte is ones-heavy, tie broken by bit 0.
  assign use_xnor = (n1d > 4'd4) ||
                    ((n1d == 4'd4) && !data_i[0]);

  always_comb begin
    qm_o    = 9'd0;
    qm_o[0] = data_i[0];
    for (int i = 1; i < 8; i++) begin
      if (use_xnor) qm_o[i] = ~(qm_o[i-1] ^ data_i[i]);
      else          qm_o[i] =   qm_o[i-1] ^ data_i[i];
    end
    qm_o[8] = ~use_xnor;
  end

  always_comb begin
    n1q_o = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n1q_o = n1q_o + {3'b000, qm_o[i]};
    end
  end

  assign n0q_o = 4'd8 - n1q_o;

endmodule

// File: rtl/tmds_channel_encoder.sv
// One TMDS channel: 8b video / 2b control / guard band -> 10b symbol,
// two pixel_en-gated pipeline stages with running disparity.
// Ports: clk, rst (sync, active-high), pixel_en strobe, data_in[7:0],
// out_sel[1:0], ctrl_in[1:0] in; tmds_out[9:0], tmds_valid out.
// Optional: TMDS_DISP_MON_EN adds disp_out (cnt after symbol) and
// disp_err (sticky |cnt|>10 after a video symbol).
module tmds_channel_encoder
  import tmds_pkg::*;
#(
  parameter int unsigned CHANNEL = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pixel_en,
  input  logic [7:0] data_in,
  input  logic [1:0] out_sel,
  input  logic [1:0] ctrl_in,
  output logic [9:0] tmds_out,
`ifdef TMDS_DISP_MON_EN
  output disp_t      disp_out,
  output logic       disp_err,
`endif
  output logic       tmds_valid
);

  localparam logic [9:0] GUARD =
    (CHANNEL == 1) ? GUARD_1 : GUARD_02;

  // Stage 1
  period_e    sel_q, sel_d;
  logic [1:0] ctrl_q, ctrl_d;
  logic [8:0] qm_q, qm_d;
  logic [3:0] n1_q, n1_d;
  logic [3:0] n0_q, n0_d;
  logic       s1v_q, s1v_d;

  // Stage 2
  logic [9:0] sym_q, sym_d;
  disp_t      cnt_q, cnt_d;
  logic       vld_q, vld_d;

  logic [8:0] qm_c;
  logic [3:0] n1_c;
  logic [3:0] n0_c;

  tmds_qm_stage u_qm (
    .data_i (data_in),
    .qm_o   (qm_c),
    .n1q_o  (n1_c),
    .n0q_o  (n0_c)
  );

  always_comb begin
    sel_d  = sel_q;
    ctrl_d = ctrl_q;
    qm_d   = qm_q;
    n1_d   = n1_q;
    n0_d   = n0_q;
    s1v_d  = s1v_q;
    if (pixel_en) begin
      sel_d  = to_period(out_sel);
      ctrl_d = ctrl_in;
      qm_d   = qm_c;
      n1_d   = n1_c;
      n0_d   = n0_c;
      s1v_d  = 1'b1;
    end
  end

  logic  qm8;
  disp_t diff;
  logic  balanced;
  logic  same_sign;

  assign qm8      = qm_q[8];
  assign diff     = ones_minus_zeros(n1_q, n0_q);
  assign balanced = (cnt_q == DISP_ZERO) || (n1_q == n0_q);
  // Running disparity and this word lean the same way: invert.
  assign same_sign =
    ((cnt_q > DISP_ZERO) && (n1_q > n0_q)) ||
    ((cnt_q < DISP_ZERO) && (n0_q > n1_q));

  always_comb begin
    sym_d = sym_q;
    cnt_d = cnt_q;
    vld_d = vld_q;
    if (pixel_en) begin
      vld_d = s1v_q;
      unique case (sel_q)
        PER_VIDEO: begin
          if (balanced) begin
            sym_d = {~qm8, qm8,
                     qm8 ? qm_q[7:0] : ~qm_q[7:0]};
            cnt_d = qm8 ? (cnt_q + diff)
                        : (cnt_q - diff);
          end else if (same_sign) begin
            sym_d = {1'b1, qm8, ~qm_q[7:0]};
            cnt_d = cnt_q - diff +
                    (qm8 ? DISP_TWO : DISP_ZERO);
          end else begin
            sym_d = {1'b0, qm8, qm_q[7:0]};
            cnt_d = cnt_q + diff -
                    (qm8 ? DISP_ZERO : DISP_TWO);
          end
        end
        PER_GUARD: begin
          sym_d = GUARD;
          cnt_d = DISP_ZERO;
        end
        default: begin
          sym_d = ctrl_code(ctrl_q);
          cnt_d = DISP_ZERO;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q  <= PER_CTRL;
      ctrl_q <= 2'b00;
      qm_q   <= 9'd0;
      n1_q   <= 4'd0;
      n0_q   <= 4'd0;
      s1v_q  <= 1'b0;
      sym_q  <= CTRL_00;
      cnt_q  <= DISP_ZERO;
      vld_q  <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      ctrl_q <= ctrl_d;
      qm_q   <= qm_d;
      n1_q   <= n1_d;
      n0_q   <= n0_d;
      s1v_q  <= s1v_d;
      sym_q  <= sym_d;
      cnt_q  <= cnt_d;
      vld_q  <= vld_d;
    end
  end

  assign tmds_out   = sym_q;
  assign tmds_valid = vld_q;

`ifdef TMDS_DISP_MON_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (pixel_en && (sel_q == PER_VIDEO) &&
        ((cnt_d > 6'sd10) || (cnt_d < -6'sd10))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign disp_out = cnt_q;
  assign disp_err = err_q;
`endif

endmodule
